// File: rtl/q_update_ctrl_if.sv
// Bundle of the Q-update request, action-RAM read/write and result signals.
// The master side is the requester plus the RAM bank; the slave side is the controller.
interface q_update_ctrl_if #(
    parameter int SA_W = 4,
    parameter int Q_W  = 16
);
    logic                   start;
    logic                   terminal;
    logic [SA_W-1:0]        state;
    logic [SA_W-1:0]        next_state;
    logic [3:0]             action;
    logic signed [Q_W-1:0]  reward;
    logic signed [Q_W-1:0]  gamma;
    logic signed [Q_W-1:0]  alpha;
    logic                   busy;
    logic                   done;
    logic                   rd_en;
    logic [SA_W-1:0]        rd_addr;
    logic [3:0]             rd_sel;
    logic signed [Q_W-1:0]  rd_data;
    logic [15:0]            wr_en;
    logic [SA_W-1:0]        wr_addr;
    logic signed [Q_W-1:0]  wr_data;
    logic signed [Q_W-1:0]  max_q;
    logic [3:0]             best_action;

    modport master (
        output start, terminal, state, next_state, action, reward, gamma, alpha, rd_data,
        input  busy, done, rd_en, rd_addr, rd_sel, wr_en, wr_addr, wr_data, max_q, best_action
    );

    modport slave (
        input  start, terminal, state, next_state, action, reward, gamma, alpha, rd_data,
        output busy, done, rd_en, rd_addr, rd_sel, wr_en, wr_addr, wr_data, max_q, best_action
    );
endinterface

// File: rtl/q_update_ctrl.sv
// Q-learning update controller: reads Q(s,a), scans Q(s',*) for max/argmax,
// computes the saturated TD update and writes it back to the selected action RAM.
module q_update_ctrl #(
    parameter int SA_W = 4,
    parameter int Q_W  = 16,
    parameter int FRAC = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    q_update_ctrl_if.slave bus
);

    localparam int W = 2 * Q_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_CUR = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_CALC   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic signed [W-1:0] Q_MAX_W = W'(2 ** (Q_W - 1) - 1);
    localparam logic signed [W-1:0] Q_MIN_W = ~Q_MAX_W;

    function automatic logic signed [Q_W-1:0] sat_q(input logic signed [W-1:0] v);
        if (v > Q_MAX_W) begin
            return Q_MAX_W[Q_W-1:0];
        end
        if (v < Q_MIN_W) begin
            return Q_MIN_W[Q_W-1:0];
        end
        return v[Q_W-1:0];
    endfunction

    // Intermediates stay wide so only the final result is ever clipped.
    function automatic logic signed [Q_W-1:0] q_update(
        input logic signed [Q_W-1:0] q_cur,
        input logic signed [Q_W-1:0] max_v,
        input logic signed [Q_W-1:0] rwd,
        input logic signed [Q_W-1:0] gam,
        input logic signed [Q_W-1:0] alp
    );
        logic signed [W-1:0] target;
        logic signed [W-1:0] td;
        logic signed [W-1:0] new_q;
        target = W'(rwd) + ((W'(gam) * W'(max_v)) >>> FRAC);
        td     = target - W'(q_cur);
        new_q  = W'(q_cur) + ((W'(alp) * td) >>> FRAC);
        return sat_q(new_q);
    endfunction

    logic [2:0]            st;
    logic [3:0]            k;
    logic [SA_W-1:0]       lat_state;
    logic [SA_W-1:0]       lat_ns;
    logic [3:0]            lat_action;
    logic signed [Q_W-1:0] lat_reward;
    logic signed [Q_W-1:0] lat_gamma;
    logic signed [Q_W-1:0] lat_alpha;
    logic                  lat_term;

    logic [SA_W-1:0]       rd_addr_c;
    logic [SA_W-1:0]       rd_addr_q;
    logic [3:0]            rd_sel_c;
    logic [3:0]            rd_sel_q;

    logic                  cur_vld_p0;
    logic                  scan_vld_p0;
    logic [3:0]            scan_k_p0;
    logic signed [Q_W-1:0] q_cur_p1;
    logic signed [Q_W-1:0] run_max_p1;
    logic [3:0]            run_best_p1;
    logic signed [Q_W-1:0] max_q_p2;
    logic [3:0]            best_p2;
    logic signed [Q_W-1:0] wr_data_p2;
    logic signed [Q_W-1:0] eff_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            k          <= '0;
            lat_state  <= '0;
            lat_ns     <= '0;
            lat_action <= '0;
            lat_reward <= '0;
            lat_gamma  <= '0;
            lat_alpha  <= '0;
            lat_term   <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (bus.start) begin
                        lat_state  <= bus.state;
                        lat_ns     <= bus.next_state;
                        lat_action <= bus.action;
                        lat_reward <= bus.reward;
                        lat_gamma  <= bus.gamma;
                        lat_alpha  <= bus.alpha;
                        lat_term   <= bus.terminal;
                        st         <= S_RD_CUR;
                    end
                end
                S_RD_CUR: begin
                    k  <= '0;
                    st <= lat_term ? S_WAIT : S_SCAN;
                end
                S_SCAN: begin
                    k <= k + 4'd1;
                    if (k == 4'd15) begin
                        st <= S_WAIT;
                    end
                end
                S_WAIT:  st <= S_CALC;
                S_CALC:  st <= S_WRITE;
                S_WRITE: st <= S_DONE;
                S_DONE:  st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_addr_c = rd_addr_q;
        rd_sel_c  = rd_sel_q;
        if (st == S_RD_CUR) begin
            rd_addr_c = lat_state;
            rd_sel_c  = lat_action;
        end else if (st == S_SCAN) begin
            rd_addr_c = lat_ns;
            rd_sel_c  = k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rd_sel_q  <= '0;
        end else begin
            rd_addr_q <= rd_addr_c;
            rd_sel_q  <= rd_sel_c;
        end
    end

    // Stage p0: remember which kind of read was issued; rd_data answers one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_vld_p0  <= 1'b0;
            scan_vld_p0 <= 1'b0;
            scan_k_p0   <= '0;
        end else begin
            cur_vld_p0  <= (st == S_RD_CUR);
            scan_vld_p0 <= (st == S_SCAN);
            scan_k_p0   <= k;
        end
    end

    // Stage p1: capture Q(s,a) and fold each scan result into the running max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cur_p1    <= '0;
            run_max_p1  <= '0;
            run_best_p1 <= '0;
        end else begin
            if (cur_vld_p0) begin
                q_cur_p1 <= bus.rd_data;
            end
            if (scan_vld_p0 && ((scan_k_p0 == 4'd0) || (bus.rd_data > run_max_p1))) begin
                run_max_p1  <= bus.rd_data;
                run_best_p1 <= scan_k_p0;
            end
        end
    end

    assign eff_max = lat_term ? '0 : run_max_p1;

    // Stage p2: results are published only in CALC and hold until the next CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q_p2   <= '0;
            best_p2    <= '0;
            wr_data_p2 <= '0;
        end else if (st == S_CALC) begin
            max_q_p2   <= eff_max;
            best_p2    <= lat_term ? 4'd0 : run_best_p1;
            wr_data_p2 <= q_update(q_cur_p1, eff_max, lat_reward, lat_gamma, lat_alpha);
        end
    end

    assign bus.busy        = (st != S_IDLE) && (st != S_DONE);
    assign bus.done        = (st == S_DONE);
    assign bus.rd_en       = (st == S_RD_CUR) || (st == S_SCAN);
    assign bus.rd_addr     = rd_addr_c;
    assign bus.rd_sel      = rd_sel_c;
    assign bus.wr_en       = (st == S_WRITE) ? (16'd1 << lat_action) : 16'd0;
    assign bus.wr_addr     = lat_state;
    assign bus.wr_data     = wr_data_p2;
    assign bus.max_q       = max_q_p2;
    assign bus.best_action = best_p2;

endmodule

// File: tb/tb_q_update_ctrl.sv
// Bench for q_update_ctrl: directed and random Q-updates against a plain-arithmetic
// reference of the update rule, with a synchronous-read model of the 16 action RAMs.
module tb_q_update_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    q_update_ctrl_if #(.SA_W(4), .Q_W(16)) bus ();

    q_update_ctrl #(.SA_W(4), .Q_W(16), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Action RAM bank, indexed [action][state]; one-cycle read latency.
    logic signed [15:0] mem [16][16];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_sel][bus.rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0]         exp_s, exp_ns, exp_a, exp_best;
    logic               exp_term;
    logic signed [15:0] exp_wr, exp_max;
    int                 exp_cyc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    endtask

    function automatic void ref_model(input logic [3:0] s, input logic [3:0] ns, input logic [3:0] a,
                                      input logic signed [15:0] r, input logic signed [15:0] g,
                                      input logic signed [15:0] al, input logic term);
        longint qc, mx, tgt, td, nq;
        int best;
        qc = mem[a][s];
        mx = 0;
        best = 0;
        if (!term) begin
            mx = mem[0][ns];
            for (int i = 1; i < 16; i++) begin
                if (mem[i][ns] > mx) begin
                    mx = mem[i][ns];
                    best = i;
                end
            end
        end
        tgt = longint'(r) + ((longint'(g) * mx) >>> 8);
        td  = tgt - qc;
        nq  = qc + ((longint'(al) * td) >>> 8);
        if (nq > 32767) nq = 32767;
        if (nq < -32768) nq = -32768;
        exp_wr   = 16'(nq);
        exp_max  = 16'(mx);
        exp_best = 4'(best);
        exp_cyc  = term ? 5 : 21;
        exp_s    = s;
        exp_ns   = ns;
        exp_a    = a;
        exp_term = term;
    endfunction

    task automatic prep(input logic [3:0] s, input logic [3:0] ns, input logic [3:0] a,
                        input logic signed [15:0] r, input logic signed [15:0] g,
                        input logic signed [15:0] al, input logic term);
        bus.state      = s;
        bus.next_state = ns;
        bus.action     = a;
        bus.reward     = r;
        bus.gamma      = g;
        bus.alpha      = al;
        bus.terminal   = term;
        bus.start      = 1'b1;
        ref_model(s, ns, a, r, g, al, term);
    endtask

    // Called one step after the accepting edge (cycle 1); watches until done or a budget expires.
    task automatic finish_req(input logic settle);
        int cyc, wr_cnt;
        logic ns_rd, busy_bad;
        logic [15:0] wr_cap;
        logic [3:0] wa_cap;
        logic [15:0] wd_cap;
        cyc = 1; wr_cnt = 0; ns_rd = 1'b0; busy_bad = 1'b0;
        wr_cap = '0; wa_cap = '0; wd_cap = '0;
        forever begin
            if (bus.wr_en != 16'd0) begin
                wr_cnt++;
                wr_cap = bus.wr_en;
                wa_cap = bus.wr_addr;
                wd_cap = bus.wr_data;
            end
            if (exp_term && bus.rd_en && (bus.rd_addr == exp_ns)) ns_rd = 1'b1;
            if (!bus.done && !bus.busy) busy_bad = 1'b1;
            if (bus.done || cyc >= 40) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_cycle", 16'(cyc), 16'(exp_cyc));
        chk("wr_pulse_count", 16'(wr_cnt), 16'd1);
        chk("wr_en_onehot", wr_cap, 16'd1 << exp_a);
        chk("wr_addr", 16'(wa_cap), 16'(exp_s));
        chk("wr_data_at_write", wd_cap, exp_wr);
        chk("wr_data_held", bus.wr_data, exp_wr);
        chk("max_q", bus.max_q, exp_max);
        chk("best_action", 16'(bus.best_action), 16'(exp_best));
        chk("busy_in_done", 16'(bus.busy), 16'd0);
        chk("busy_gap", 16'(busy_bad), 16'd0);
        if (exp_term) chk("terminal_ns_read", 16'(ns_rd), 16'd0);
        if (settle) begin
            @(posedge clk); #1;
            chk("done_one_cycle", 16'(bus.done), 16'd0);
        end
    endtask

    task automatic run(input logic [3:0] s, input logic [3:0] ns, input logic [3:0] a,
                       input logic signed [15:0] r, input logic signed [15:0] g,
                       input logic signed [15:0] al, input logic term);
        prep(s, ns, a, r, g, al, term);
        @(posedge clk); #1;
        bus.start = 1'b0;
        finish_req(1'b1);
    endtask

    initial begin
        int wr_after;
        logic [3:0] rs, rns, ra;
        logic signed [15:0] rr, rg, ral;
        logic rt;

        rst_n = 1'b1;
        bus.start = 1'b0; bus.terminal = 1'b0; bus.state = '0; bus.next_state = '0;
        bus.action = '0; bus.reward = '0; bus.gamma = '0; bus.alpha = '0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) mem[i][j] = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_rd_en", 16'(bus.rd_en), 16'd0);
        chk("rst_wr_en", bus.wr_en, 16'd0);
        chk("rst_rd_addr", 16'(bus.rd_addr), 16'd0);
        chk("rst_rd_sel", 16'(bus.rd_sel), 16'd0);
        chk("rst_wr_data", bus.wr_data, 16'd0);
        chk("rst_max_q", bus.max_q, 16'd0);
        chk("rst_best", 16'(bus.best_action), 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero table: 1.0 + 0.5*0 -> half step towards 1.0
        run(4'd3, 4'd5, 4'd6, 16'sh0100, 16'sh0080, 16'sh0080, 1'b0);
        chk("zero_table_wr", bus.wr_data, 16'h0080);

        for (int i = 0; i < 16; i++) mem[i][7] = 16'(i * 256);
        run(4'd4, 4'd7, 4'd2, 16'sh0000, 16'sh0100, 16'sh0100, 1'b0);
        chk("ramp_max", bus.max_q, 16'h0F00);
        chk("ramp_best", 16'(bus.best_action), 16'd15);
        chk("ramp_wr", bus.wr_data, 16'h0F00);

        for (int i = 0; i < 16; i++) mem[i][1] = 16'sh0200;
        run(4'd0, 4'd1, 4'd0, 16'sh0100, 16'sh0080, 16'sh0080, 1'b0);
        chk("tie_best", 16'(bus.best_action), 16'd0);

        for (int i = 0; i < 16; i++) mem[i][2] = 16'shFF00;
        mem[9][2] = 16'shFF80;
        run(4'd5, 4'd2, 4'd3, 16'sh0100, 16'sh0080, 16'sh0080, 1'b0);
        chk("neg_best", 16'(bus.best_action), 16'd9);
        chk("neg_max", bus.max_q, 16'hFF80);

        for (int i = 0; i < 16; i++) mem[i][10] = 16'sh7000;
        mem[4][8] = 16'sh7000;
        run(4'd8, 4'd10, 4'd4, 16'sh7F00, 16'sh0100, 16'sh0100, 1'b0);
        chk("sat_pos", bus.wr_data, 16'h7FFF);

        for (int i = 0; i < 16; i++) mem[i][11] = 16'sh9000;
        mem[5][12] = 16'sh9000;
        run(4'd12, 4'd11, 4'd5, 16'sh8100, 16'sh0100, 16'sh0100, 1'b0);
        chk("sat_neg", bus.wr_data, 16'h8000);

        // Terminal update, then a start held across DONE into the following IDLE cycle
        mem[1][2] = 16'sh0100;
        prep(4'd2, 4'd9, 4'd1, 16'sh0200, 16'sh0080, 16'sh0100, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        finish_req(1'b0);
        chk("term_wr", bus.wr_data, 16'h0200);
        chk("term_max", bus.max_q, 16'h0000);

        prep(4'd3, 4'd5, 4'd6, 16'sh0100, 16'sh0080, 16'sh0080, 1'b0);
        @(posedge clk); #1;
        chk("b2b_ignored_in_done", 16'(bus.busy), 16'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_accepted_in_idle", 16'(bus.busy), 16'd1);
        finish_req(1'b1);
        chk("b2b_wr", bus.wr_data, 16'h0080);

        // Abort during SCAN k=7, then restart right after reset release
        for (int i = 0; i < 16; i++) mem[i][13] = 16'(i * 16);
        mem[7][6] = 16'sh0040;
        prep(4'd6, 4'd13, 4'd7, 16'sh0300, 16'sh0100, 16'sh0080, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_at_k7", 16'(bus.rd_sel), 16'd7);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_rd_en", 16'(bus.rd_en), 16'd0);
        wr_after = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.wr_en != 16'd0) wr_after++;
        end
        chk("abort_no_write", 16'(wr_after), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prep(4'd6, 4'd13, 4'd7, 16'sh0300, 16'sh0100, 16'sh0080, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        finish_req(1'b1);

        for (int it = 0; it < 24; it++) begin
            rs  = 4'($urandom_range(0, 15));
            rns = rs ^ 4'($urandom_range(1, 15));
            ra  = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                if (it % 3 == 0) mem[i][rns] = 16'(int'($urandom_range(0, 3)) * 256);
                else             mem[i][rns] = 16'($urandom);
            end
            mem[ra][rs] = 16'($urandom);
            rr  = 16'($urandom);
            rg  = 16'(int'($urandom_range(0, 1024)) - 512);
            ral = 16'(int'($urandom_range(0, 1024)) - 512);
            rt  = ($urandom_range(0, 3) == 0);
            run(rs, rns, ra, rr, rg, ral, rt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/q_update_ctrl.md
Q_UPDATE_CTRL -- requirements
Module: q_update_ctrl

Interface
REQ-001 Parameter SA_W, default 4: width of the state address into each action RAM.
REQ-002 Parameter Q_W, default 16: width of Q-values, reward, gamma and alpha, all signed fixed point.
REQ-003 Parameter FRAC, default 8: number of fraction bits, giving the Q8.8 format.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low; port names are clk and rst_n.
REQ-005 The ports SHALL be as listed below.
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request one Q-update.
- terminal, input, 1: next_state is terminal; max Q is forced to 0.
- state, input, SA_W: current state.
- next_state, input, SA_W: successor state.
- action, input, 4: action taken.
- reward, input, Q_W: signed Q8.8.
- gamma, input, Q_W: signed Q8.8.
- alpha, input, Q_W: signed Q8.8.
- busy, output, 1: an update is in progress.
- done, output, 1: one-cycle completion pulse.
- rd_en, output, 1: action-RAM read enable.
- rd_addr, output, SA_W: RAM read address.
- rd_sel, output, 4: read action select, driven to the 16:1 mux.
- rd_data, input, Q_W: mux output, valid 1 cycle after rd_en/rd_addr/rd_sel.
- wr_en, output, 16: one-hot write enable, one bit per action RAM.
- wr_addr, output, SA_W: RAM write address.
- wr_data, output, Q_W: new Q-value.
- max_q, output, Q_W: registered max over Q(next_state,*).
- best_action, output, 4: registered argmax.

Function
REQ-006 The FSM SHALL have the states IDLE, RD_CUR, SCAN, WAIT, CALC, WRITE and DONE.
REQ-007 In IDLE with start=1, the block SHALL latch state, next_state, action, reward, gamma, alpha and terminal, and go to RD_CUR; start SHALL be ignored in every other state.
REQ-008 RD_CUR (1 cycle) SHALL drive rd_en=1, rd_addr=state and rd_sel=action; the next state SHALL be SCAN if terminal=0, else WAIT.
REQ-009 SCAN (16 cycles, counter k=0..15) SHALL drive rd_en=1, rd_addr=next_state and rd_sel=k.
REQ-010 The block SHALL register q_cur from rd_data in the first cycle after RD_CUR.
REQ-011 The block SHALL compare rd_data against the running max in each cycle after a SCAN read, including the WAIT cycle.
REQ-012 WAIT SHALL last 1 cycle and then go to CALC; rd_en SHALL be 0 in WAIT.
REQ-013 The max comparison SHALL be signed; the running max SHALL be initialised from the k=0 read; a strictly greater value SHALL replace it, so ties keep the lowest index.
REQ-014 If terminal=1, the block SHALL set max_q=0 and best_action=0, and SHALL issue no reads with next_state.
REQ-015 CALC (1 cycle) SHALL compute and register the update using signed arithmetic at 2*Q_W+2 bits:
- target = reward + ((gamma*max_q) >>> FRAC)
- td = target - q_cur
- new_q = q_cur + ((alpha*td) >>> FRAC)
- >>> is an arithmetic shift.
REQ-016 new_q SHALL be saturated once, at the end, to the range [-2^(Q_W-1), 2^(Q_W-1)-1].
REQ-017 WRITE (1 cycle) SHALL drive wr_en = one-hot(action) together with wr_addr=state and wr_data=new_q; wr_en SHALL be all-zero in every other cycle.
REQ-018 DONE (1 cycle) SHALL set done=1 and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE and DONE.
REQ-020 Latency measured from the cycle start is sampled:
- terminal=0: done SHALL occur in cycle 21.
- terminal=1: done SHALL occur in cycle 5.
REQ-021 A start in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted, giving a back-to-back period of 22 cycles.
REQ-022 max_q, best_action and wr_data SHALL hold their values until the next update reaches CALC.
REQ-023 Outside RD_CUR and SCAN, rd_addr and rd_sel SHALL hold their last values.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force state IDLE and clear to 0: busy, done, rd_en, wr_en, rd_addr, rd_sel, wr_addr, wr_data, max_q, best_action, k and all latched inputs.
REQ-025 A reset asserted mid-operation SHALL abort the update; no wr_en bit SHALL assert afterwards, and the block SHALL accept start in the first cycle after rst_n rises.

Verification
REQ-026 All Q=0, reward=0x0100, gamma=0x0080, alpha=0x0080, terminal=0 -> max_q=0, wr_data=0x0080, wr_en=one-hot(action), done in cycle 21.
REQ-027 Q(ns,k)=k*0x0100, Q(s,a)=0, reward=0, gamma=0x0100, alpha=0x0100 -> max_q=0x0F00, best_action=15, wr_data=0x0F00.
REQ-028 All Q(ns,k)=0x0200, Q(s,a)=0 -> best_action=0; Q(ns,k)=0xFF00 (-1.0) for all k except Q(ns,9)=0xFF80 -> best_action=9, max_q=0xFF80.
REQ-029 Q(s,a)=0x7000, max=0x7000, reward=0x7F00, gamma=alpha=0x0100 -> wr_data=0x7FFF (saturated); a mirrored negative case -> 0x8000.
REQ-030 terminal=1, Q(s,a)=0x0100, reward=0x0200, alpha=0x0100 -> rd_en is never asserted with rd_addr=next_state, wr_data=0x0200, done in cycle 5.
REQ-031 rst_n pulsed low during SCAN k=7 -> busy=0 at once, wr_en stays 0; a start issued afterwards completes normally with correct wr_data.
